conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined float-to-int16 converter (`conv`) between two requester lanes of the GhostSZ compression datapath. It accepts 32-bit IEEE-754 samples from either lane with a valid/ready handshake and drives the converter input. It tracks each in-flight sample by requester tag through the converter's fixed latency and routes the 16-bit result plus overflow/underflow flags back to the originating lane. It also keeps saturating overflow/underflow event counters for the block-level statistics logic.

---
 rtl/conv_arbiter_if.sv | 47 ++++
 rtl/conv_arbiter.sv | 109 ++++++++++
 tb/tb_conv_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_arbiter_if.sv
// Bundle of lane handshakes, converter hookup, responses and statistics for conv_arbiter.
// The arbiter uses the slave view; the environment (lanes, converter, stats) uses master.
interface conv_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [31:0]      req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [31:0]      req1_data;
  logic             req1_ready;

  logic [31:0]      conv_in;
  logic [15:0]      conv_out;
  logic             conv_ovf;
  logic             conv_unf;

  logic             resp0_valid;
  logic [15:0]      resp0_data;
  logic [1:0]       resp0_flag;
  logic             resp1_valid;
  logic [15:0]      resp1_data;
  logic [1:0]       resp1_flag;

  logic             clr_counts;
  logic [CNT_W-1:0] ovf_count;
  logic [CNT_W-1:0] unf_count;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  conv_out, conv_ovf, conv_unf, clr_counts,
    output req0_ready, req1_ready, conv_in,
    output resp0_valid, resp0_data, resp0_flag,
    output resp1_valid, resp1_data, resp1_flag,
    output ovf_count, unf_count, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output conv_out, conv_ovf, conv_unf, clr_counts,
    input  req0_ready, req1_ready, conv_in,
    input  resp0_valid, resp0_data, resp0_flag,
    input  resp1_valid, resp1_data, resp1_flag,
    input  ovf_count, unf_count, busy
  );
endinterface

// File: rtl/conv_arbiter.sv
// Two-lane round-robin front end for a shared pipelined float-to-int16 converter,
// with tag tracking for result routing and saturating overflow/underflow counters.
module conv_arbiter #(
  parameter int CONV_LAT = 2,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  conv_arbiter_if.slave  bus
);

  // conv_in is itself a register, so the tag needs one extra stage beyond the
  // converter latency to line up with conv_out at the retire edge.
  localparam int DEPTH = CONV_LAT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_ptr;
  logic [DEPTH-1:0] r_tag_v;
  logic [DEPTH-1:0] r_tag_id;
  logic [31:0]      r_conv_in;

  logic             r_resp0_valid;
  logic [15:0]      r_resp0_data;
  logic [1:0]       r_resp0_flag;
  logic             r_resp1_valid;
  logic [15:0]      r_resp1_data;
  logic [1:0]       r_resp1_flag;

  logic [CNT_W-1:0] r_ovf_count;
  logic [CNT_W-1:0] r_unf_count;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt;
  logic             w_ret;
  logic             w_ret_id;

  assign w_gnt0   = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
  assign w_gnt1   = bus.req1_valid & (~bus.req0_valid |  r_ptr);
  assign w_gnt    = w_gnt0 | w_gnt1;
  assign w_ret    = r_tag_v[DEPTH-1];
  assign w_ret_id = r_tag_id[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_tag_v   <= '0;
      r_tag_id  <= '0;
      r_conv_in <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[DEPTH-2:0], w_gnt};
      r_tag_id <= {r_tag_id[DEPTH-2:0], w_gnt1};
      if (w_gnt) begin
        r_conv_in <= w_gnt1 ? bus.req1_data : bus.req0_data;
        r_ptr     <= w_gnt0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp0_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp0_flag  <= '0;
      r_resp1_valid <= 1'b0;
      r_resp1_data  <= '0;
      r_resp1_flag  <= '0;
    end else begin
      r_resp0_valid <= w_ret & ~w_ret_id;
      r_resp1_valid <= w_ret &  w_ret_id;
      if (w_ret && !w_ret_id) begin
        r_resp0_data <= bus.conv_out;
        r_resp0_flag <= {bus.conv_ovf, bus.conv_unf};
      end
      if (w_ret && w_ret_id) begin
        r_resp1_data <= bus.conv_out;
        r_resp1_flag <= {bus.conv_ovf, bus.conv_unf};
      end
    end
  end

  // Clear wins over a same-edge increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_count <= '0;
      r_unf_count <= '0;
    end else if (bus.clr_counts) begin
      r_ovf_count <= '0;
      r_unf_count <= '0;
    end else if (w_ret) begin
      if (bus.conv_ovf && r_ovf_count != CNT_MAX) r_ovf_count <= r_ovf_count + 1'b1;
      if (bus.conv_unf && r_unf_count != CNT_MAX) r_unf_count <= r_unf_count + 1'b1;
    end
  end

  assign bus.req0_ready  = w_gnt0;
  assign bus.req1_ready  = w_gnt1;
  assign bus.conv_in     = r_conv_in;
  assign bus.resp0_valid = r_resp0_valid;
  assign bus.resp0_data  = r_resp0_data;
  assign bus.resp0_flag  = r_resp0_flag;
  assign bus.resp1_valid = r_resp1_valid;
  assign bus.resp1_data  = r_resp1_data;
  assign bus.resp1_flag  = r_resp1_flag;
  assign bus.ovf_count   = r_ovf_count;
  assign bus.unf_count   = r_unf_count;
  assign bus.busy        = |r_tag_v;

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter: a 2-cycle truncating float-to-int16 converter
// stub, per-lane request queues, and a negedge monitor that pops expected results.
module tb_conv_arbiter;
  localparam int CONV_LAT = 2;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_arbiter_if #(.CNT_W(CNT_W)) bus ();

  conv_arbiter #(.CONV_LAT(CONV_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        lane;
    logic [15:0] data;
    logic [1:0]  flag;
    int          cyc;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  lq0[$];
  logic [31:0]  lq1[$];
  bit           took0, took1;
  int           n_cmp = 0, n_bad = 0;
  int           cyc = 0;
  int           gcount = 0;
  int           n_resp1 = 0;
  logic         ptr_m = 1'b0;
  logic         clr_prev = 1'b0;
  logic [CNT_W-1:0] eo = '0, eu = '0;
  logic [15:0]  last_d0 = '0, last_d1 = '0;
  logic [1:0]   last_f0 = '0, last_f1 = '0;
  logic         grant_log[$];
  int           resp_log[$];
  logic [17:0]  p1 = '0, p2 = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // {ovf, unf, int16}: truncate toward zero, saturate outside int16 range
  function automatic logic [17:0] f2i(input logic [31:0] b);
    logic [23:0] mag;
    int          e;
    e = int'(b[30:23]);
    if (e < 127) return 18'd0;
    if (e >= 142) begin
      if (!b[31]) return {2'b10, 16'h7fff};
      if (e == 142 && b[22:0] == 23'd0) return {2'b00, 16'h8000};
      return {2'b01, 16'h8000};
    end
    mag = {1'b1, b[22:0]} >> (150 - e);
    return {2'b00, b[31] ? 16'(-mag[15:0]) : mag[15:0]};
  endfunction

  always @(posedge clk) begin
    p1 <= f2i(bus.conv_in);
    p2 <= p1;
  end
  assign bus.conv_out = p2[15:0];
  assign bus.conv_ovf = p2[17];
  assign bus.conv_unf = p2[16];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Lane drivers: present queue heads, advance after a grant
  initial forever begin
    @(posedge clk);
    #1;
    if (took0) begin void'(lq0.pop_front()); took0 = 1'b0; end
    if (took1) begin void'(lq1.pop_front()); took1 = 1'b0; end
    bus.req0_valid = (lq0.size() > 0);
    bus.req0_data  = (lq0.size() > 0) ? lq0[0] : 32'h0;
    bus.req1_valid = (lq1.size() > 0);
    bus.req1_data  = (lq1.size() > 0) ? lq1[0] : 32'h0;
  end

  task automatic retire(input logic lane, input logic [15:0] d, input logic [1:0] f);
    exp_t e;
    resp_log.push_back(cyc);
    if (sb.size() == 0) begin
      chk(lane ? "unexp_resp1" : "unexp_resp0", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("resp_lane", {31'd0, lane}, {31'd0, e.lane});
    chk("resp_data", {16'd0, d}, {16'd0, e.data});
    chk("resp_flag", {30'd0, f}, {30'd0, e.flag});
    chk("resp_lat", cyc - e.cyc, CONV_LAT + 2);
    if (!clr_prev) begin
      if (e.flag[1] && eo != '1) eo = eo + 1'b1;
      if (e.flag[0] && eu != '1) eu = eu + 1'b1;
    end
  endtask

  task automatic grant(input logic lane, input logic [31:0] d);
    exp_t e;
    logic [17:0] r;
    r = f2i(d);
    e.lane = lane; e.data = r[15:0]; e.flag = r[17:16]; e.cyc = cyc;
    sb.push_back(e);
    grant_log.push_back(lane);
    ptr_m = ~lane;
    gcount++;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      ptr_m = 1'b0; eo = '0; eu = '0; clr_prev = 1'b0;
    end else begin
      if (clr_prev) begin eo = '0; eu = '0; end
      if (bus.resp0_valid) begin
        last_d0 = bus.resp0_data; last_f0 = bus.resp0_flag;
        retire(1'b0, bus.resp0_data, bus.resp0_flag);
      end
      if (bus.resp1_valid) begin
        n_resp1++;
        last_d1 = bus.resp1_data; last_f1 = bus.resp1_flag;
        retire(1'b1, bus.resp1_data, bus.resp1_flag);
      end
      chk("ovf_count", {28'd0, bus.ovf_count}, {28'd0, eo});
      chk("unf_count", {28'd0, bus.unf_count}, {28'd0, eu});
      chk("busy", {31'd0, bus.busy}, {31'd0, sb.size() != 0});
      if (bus.req0_ready && !bus.req0_valid) chk("ready0_wo_valid", 32'd1, 32'd0);
      if (bus.req1_ready && !bus.req1_valid) chk("ready1_wo_valid", 32'd1, 32'd0);
      if (bus.req0_ready && bus.req1_ready)  chk("dual_grant", 32'd1, 32'd0);
      if (bus.req0_valid && bus.req1_valid)
        chk("rr_ptr", {31'd0, bus.req1_ready}, {31'd0, ptr_m});
      if (bus.req0_ready) begin grant(1'b0, bus.req0_data); took0 = 1'b1; end
      if (bus.req1_ready) begin grant(1'b1, bus.req1_data); took1 = 1'b1; end
      clr_prev = bus.clr_counts;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #3;
      if (lq0.size() == 0 && lq1.size() == 0 && sb.size() == 0 && !bus.busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #3;
      if (gcount >= target) return;
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] f;
    int          base;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.clr_counts = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_conv_in", bus.conv_in, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_resp_valid", {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
    chk("rst_resp_data", {bus.resp0_data, bus.resp1_data}, 32'd0);
    chk("rst_counts", {24'd0, bus.ovf_count, bus.unf_count}, 32'd0);
    @(posedge clk); #3; rst = 1'b0;

    // single lane-0 sample
    lq0.push_back(32'h3fdae148);
    wait_idle();
    chk("t1_data", {16'd0, last_d0}, 32'h0001);
    chk("t1_flag", {30'd0, last_f0}, 32'd0);
    chk("t1_no_resp1", n_resp1, 0);

    // overflow on lane 1, then underflow on lane 0
    lq1.push_back(32'h47000000);
    wait_idle();
    chk("t2_data1", {16'd0, last_d1}, 32'h7fff);
    chk("t2_flag1", {30'd0, last_f1}, 32'd2);
    chk("t2_ovf", {28'd0, bus.ovf_count}, 32'd1);
    lq0.push_back(32'hc7000100);
    wait_idle();
    chk("t2_data0", {16'd0, last_d0}, 32'h8000);
    chk("t2_flag0", {30'd0, last_f0}, 32'd1);
    chk("t2_unf", {28'd0, bus.unf_count}, 32'd1);

    // both lanes contending for six cycles
    grant_log.delete(); resp_log.delete();
    for (int i = 0; i < 3; i++) begin
      lq0.push_back(32'h40400000 + 32'(i) * 32'h00100000);
      lq1.push_back(32'hc1200000 - 32'(i) * 32'h00080000);
    end
    wait_idle();
    chk("t3_grants", grant_log.size(), 6);
    chk("t3_resps", resp_log.size(), 6);
    for (int i = 1; i < 6 && i < grant_log.size() && i < resp_log.size(); i++) begin
      chk("t3_alternate", {31'd0, grant_log[i]}, {31'd0, ~grant_log[i-1]});
      chk("t3_no_gap", resp_log[i], resp_log[i-1] + 1);
    end

    // reset with two samples in flight
    base = gcount;
    lq0.push_back(32'h42000000);
    lq1.push_back(32'h42800000);
    wait_grants(base + 2);
    rst = 1'b1;
    lq0.delete(); lq1.delete(); took0 = 1'b0; took1 = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #3; rst = 1'b0;
    resp_log.delete();
    repeat (6) @(posedge clk);
    #3;
    chk("t4_no_resp", resp_log.size(), 0);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    grant_log.delete();
    lq0.push_back(32'h41000000);
    lq1.push_back(32'h41100000);
    wait_idle();
    chk("t4_ptr_lane0", (grant_log.size() > 0) ? {31'd0, grant_log[0]} : 32'hffff_ffff, 32'd0);

    // mixed random samples on random lanes
    for (int i = 0; i < 24; i++) begin
      f = {$urandom_range(1, 0) == 1, 8'($urandom_range(146, 120)), 23'($urandom)};
      if ($urandom_range(1, 0) == 1) lq1.push_back(f); else lq0.push_back(f);
    end
    wait_idle();

    // drive overflow counter into saturation, then one more
    bus.clr_counts = 1'b1;
    @(posedge clk); #3; bus.clr_counts = 1'b0;
    for (int i = 0; i < 16; i++) lq1.push_back(32'h47800000);
    wait_idle();
    chk("t5_sat", {28'd0, bus.ovf_count}, 32'hf);
    lq0.push_back(32'h47000000);
    wait_idle();
    chk("t5_sat_hold", {28'd0, bus.ovf_count}, 32'hf);

    // clear held across an overflow retire
    base = gcount;
    lq0.push_back(32'h47000000);
    wait_grants(base + 1);
    bus.clr_counts = 1'b1;
    repeat (5) @(posedge clk);
    #3; bus.clr_counts = 1'b0;
    wait_idle();
    chk("t5_clr_ovf", {28'd0, bus.ovf_count}, 32'd0);
    chk("t5_clr_unf", {28'd0, bus.unf_count}, 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
